shift_unit_mc: RTL and testbench
================================

// Module: shift_unit_mc
// PURPOSE
//  Parametrised multi-cycle shift unit: SLL/SRL/SRA/ROL of a WIDTH-bit operand by a
//  runtime amount, at most STEP bit positions per clock. Successor to the fixed
//  <<2 address shifter; serves the address/offset datapath and ALU shift ops.
//  Has valid/ready handshakes on input and output, plus a synchronous flush.
// PARAMETERS
//  WIDTH    32               operand/result width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)    shift-amount width; amounts >= WIDTH are illegal
//  STEP     4                maximum bit positions shifted per cycle (power of 2, 1..WIDTH)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        sync abort: drop the in-flight op, return to IDLE
//  in_valid   in   1        operand/command valid
//  in_ready   out  1        unit can accept a command this cycle
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount
//  in_mode    in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result
//  out_ovf    out  1        SLL only: a 1 bit was shifted out (sticky over the op); else 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_ovf=0,
//    remaining count=0. in_ready=0 while rst_n=0.
//  - FSM states IDLE, BUSY, DONE. in_ready = (state==IDLE) && !flush.
//  - IDLE: on in_valid && in_ready, register data/mode; remaining=in_shamt; ovf=0.
//    shamt==0 -> DONE, else -> BUSY.
//  - BUSY: each cycle k=min(remaining,STEP); data shifted by k per mode; remaining-=k;
//    SLL: ovf |= OR of the k bits shifted out. Go to DONE when remaining-k==0.
//  - Latency accept-edge to out_valid: 1 + ceil(shamt/STEP) cycles
//    (shamt=0 -> 1; shamt=31, STEP=4 -> 9).
//  - DONE: out_valid=1; out_data/out_ovf stable while out_valid && !out_ready.
//    On out_ready -> IDLE, out_valid=0 next cycle. No accept in the same cycle
//    (max one op in flight; back-to-back throughput = latency+1).
//  - SRA fills with original MSB; SRL/SLL fill 0; ROL wraps MSBs into LSBs.
//  - flush=1 in any state: next state IDLE, out_valid=0, op discarded; flush
//    overrides a simultaneous in_valid or out_ready (no accept, no handshake).
//  - Reset mid-op: op discarded, outputs to reset values immediately.
//  - in_shamt >= WIDTH (only when WIDTH not a power of 2): result undefined, FSM
//    still terminates (remaining saturates at WIDTH-1); assertion fires in sim.
//  - in_* are ignored except when accepted; no combinational in->out path.
// STRUCTURE
//  - shifter_pkg: localparams SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10,
//    SH_ROL=2'b11; FSM state encodings ST_IDLE/ST_BUSY/ST_DONE.
//  - Sub-module shift_step (combinational): data, mode, k (0..STEP) -> shifted
//    data and shifted-out OR; instantiated once, driven from the data register.
//  - Top holds FSM, data/remaining/mode/ovf registers, handshakes.
// TESTING
//  - Reset: rst_n=0 mid-BUSY -> out_valid=0, out_data=0, in_ready=1 after release.
//  - SLL 0x0000_0001 by 31, STEP=4 -> 0x8000_0000, ovf=0, out_valid 9 cycles after
//    accept; SLL 0xC000_0000 by 1 -> 0x8000_0000, ovf=1.
//  - SRA 0x8000_00F0 by 4 -> 0xF800_000F; SRL same -> 0x0800_000F;
//    ROL 0x8000_0001 by 1 -> 0x0000_0003.
//  - shamt=0, SRL 0x1234_5678 -> 0x1234_5678 one cycle after accept.
//  - Backpressure: out_ready low 5 cycles in DONE -> out_data stable, in_ready=0;
//    out_ready high -> IDLE next cycle, next command accepted.
//  - flush in BUSY with in_valid=1 -> no output, no accept that cycle; accept next cycle.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared constants for the multi-cycle shift unit: shift-mode codes and
// FSM state encodings used by the top level and the per-step shifter.
package shifter_pkg;

    // Shift-mode codes carried on in_mode
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One iteration of the multi-cycle shifter: shifts data_in by k (0..STEP)
// positions in the selected mode and reports whether any 1 bit left the top
// of the word during an SLL. Purely combinational.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] data_out,
    output logic             lost_out
);

    // One candidate per possible step size; k selects among them. Every
    // shift amount is a constant, so each candidate is plain wiring.
    logic [WIDTH-1:0] cand [0:STEP];
    logic             lost [0:STEP];

    genvar gi;
    generate
        for (gi = 0; gi <= STEP; gi++) begin : g_amt
            logic [WIDTH-1:0] sll_w;
            logic [WIDTH-1:0] srl_w;
            logic [WIDTH-1:0] sra_w;
            logic [WIDTH-1:0] rol_w;

            assign sll_w = data_in << gi;
            assign srl_w = data_in >> gi;
            assign sra_w = $unsigned($signed(data_in) >>> gi);
            // Right shift by WIDTH-gi yields zero for gi==0, so no special case.
            assign rol_w = (data_in << gi) | (data_in >> (WIDTH - gi));

            // Pick the candidate for this step size according to the mode
            always_comb begin
                cand[gi] = sll_w;
                case (mode)
                    SH_SLL:  cand[gi] = sll_w;
                    SH_SRL:  cand[gi] = srl_w;
                    SH_SRA:  cand[gi] = sra_w;
                    default: cand[gi] = rol_w;
                endcase
            end

            // The top gi bits are the ones that fall off during a left shift
            assign lost[gi] = (mode == SH_SLL) && (|(data_in >> (WIDTH - gi)));
        end
    endgenerate

    // Select by step size; an out-of-range k leaves the data untouched
    always_comb begin
        data_out = data_in;
        lost_out = 1'b0;
        if (32'(k) <= STEP) begin
            data_out = cand[k];
            lost_out = lost[k];
        end
    end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle SLL/SRL/SRA/ROL unit. A command is captured in IDLE, shifted by
// at most STEP positions per cycle in BUSY, and held in DONE until the
// consumer takes it. One operation in flight at a time; flush aborts it.
module shift_unit_mc
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_ovf
);

    localparam int K_W = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [SHAMT_W-1:0] shamt_sat;
    logic [K_W-1:0]     step_k;
    logic               last_step;
    logic [WIDTH-1:0]   step_data;
    logic               step_lost;
    logic               accept;

    // Illegal amounts only exist when WIDTH is not a power of two; clamp them
    // so the FSM always terminates, and flag them in simulation.
    generate
        if ((1 << SHAMT_W) == WIDTH) begin : g_no_sat
            assign shamt_sat = in_shamt;
        end else begin : g_sat
            assign shamt_sat = (in_shamt > SHAMT_MAX) ? SHAMT_MAX : in_shamt;

            a_shamt_legal: assert property (@(posedge clk) disable iff (!rst_n)
                (in_valid && in_ready) |-> (in_shamt <= SHAMT_MAX));
        end
    endgenerate

    // Ready only in IDLE, never during reset, and never while flushing
    assign in_ready = rst_n && (state_q == ST_IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Step size for this cycle: k = min(remaining, STEP)
    always_comb begin
        if (32'(rem_q) >= STEP) begin
            step_k = K_W'(STEP);
        end else begin
            step_k = K_W'(rem_q);
        end
        last_step = (32'(rem_q) == 32'(step_k));
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .data_in  (data_q),
        .mode     (mode_q),
        .k        (step_k),
        .data_out (step_data),
        .lost_out (step_lost)
    );

    // Next-state logic: capture, iterate, hold result, flush abort
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = ST_IDLE;
            rem_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_d = in_data;
                        mode_d = in_mode;
                        rem_d  = shamt_sat;
                        ovf_d  = 1'b0;
                        if (shamt_sat == '0) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    data_d = step_data;
                    ovf_d  = ovf_q | step_lost;
                    rem_d  = rem_q - SHAMT_W'(step_k);
                    if (last_step) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    // The result is held untouched until the consumer takes it
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            mode_q      <= SH_SLL;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_shift_unit_mc.sv
// Scoreboard bench for shift_unit_mc: the driver pushes expected results from
// an arithmetic reference model; an independent monitor pops and compares
// whenever the unit hands over a result.
module tb_shift_unit_mc;

    localparam int W    = 32;
    localparam int SW   = 5;
    localparam int STEP = 4;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROL = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rdy_force = 1'b1;
    bit rdy_val = 1'b1;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    shift_unit_mc #(.WIDTH(W), .SHAMT_W(SW), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer: forced ready level or random backpressure
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: the shift as a whole, in plain arithmetic
    function automatic void model(input logic [31:0] d, input int s, input logic [1:0] m,
                                  output logic [31:0] r, output logic o);
        logic [63:0] w;
        o = 1'b0;
        r = d;
        case (m)
            M_SLL: begin
                w = {32'd0, d} << s;
                r = w[31:0];
                o = |w[63:32];
            end
            M_SRL: r = d >> s;
            M_SRA: r = $unsigned($signed(d) >>> s);
            default: begin
                w = {d, d} << s;
                r = w[63:32];
            end
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        exp_t e;
        model(d, int'(s), m, e.data, e.ovf);
        e.lat = 1 + (int'(s) + STEP - 1) / STEP;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    // Present a command and hold it until accepted (bounded wait)
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, input bit track);
        int  waited;
        bit  done;
        waited = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (track) push_exp(d, s, m);
            end else begin
                waited++;
                if (waited > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SW'($urandom);
        in_mode  = 2'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: latency on first valid, stability while stalled, value on handshake
    initial begin : monitor
        bit          active;
        bit          prev_hs;
        logic [31:0] hold_d;
        logic        hold_o;
        exp_t        e;
        active  = 1'b0;
        prev_hs = 1'b0;
        hold_d  = '0;
        hold_o  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs && !flush) begin
                    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
                    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    chk("in_ready_while_valid", 32'(in_ready), 32'd0);
                    if (!active) begin
                        active = 1'b1;
                        hold_d = out_data;
                        hold_o = out_ovf;
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: got 0x%08h expected no result", out_data);
                        end else begin
                            chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        end
                    end else begin
                        chk("hold_data", out_data, hold_d);
                        chk("hold_ovf", 32'(out_ovf), 32'(hold_o));
                    end
                    if (out_ready) begin
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("data", out_data, e.data);
                            chk("ovf", 32'(out_ovf), 32'(e.ovf));
                        end
                        active  = 1'b0;
                        prev_hs = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        int          n;
        int          pat;

        // Reset values while rst_n is low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases
        send(32'h0000_0001, 5'd31, M_SLL, 1'b1);
        send(32'hC000_0000, 5'd1,  M_SLL, 1'b1);
        send(32'h8000_00F0, 5'd4,  M_SRA, 1'b1);
        send(32'h8000_00F0, 5'd4,  M_SRL, 1'b1);
        send(32'h8000_0001, 5'd1,  M_ROL, 1'b1);
        send(32'h1234_5678, 5'd0,  M_SRL, 1'b1);
        wait_drain();

        // Backpressure: hold the result for five cycles, then release
        rdy_val = 1'b0;
        send(32'hA5A5_0F0F, 5'd7, M_ROL, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        rdy_val = 1'b1;
        send(32'hFFFF_0000, 5'd9, M_SRA, 1'b1);
        wait_drain();

        // Flush mid-BUSY with a command waiting: no accept that cycle, accept next
        send(32'hDEAD_BEEF, 5'd29, M_SLL, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0F0F_1234;
        in_shamt = 5'd3;
        in_mode  = M_SRL;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        chk("post_flush_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) push_exp(32'h0F0F_1234, 5'd3, M_SRL);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset in the middle of an operation
        send(32'h1357_9BDF, 5'd30, M_SRA, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        chk("after_rst_out_valid", 32'(out_valid), 32'd0);

        // Randomised traffic with random backpressure
        rdy_force = 1'b0;
        for (int i = 0; i < 150; i++) begin
            pat = int'($urandom_range(0, 4));
            case (pat)
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
                2:       d = 32'h0000_0001 << $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            send(d, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        wait_drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
